// File: rtl/simon_checker.sv
// simon_checker: records Simon's colour sequence, then checks the player's presses against it.
// Optional build macro SIMON_TIMEOUT_EN adds a per-press inactivity timeout.
`default_nettype none

module simon_checker #(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              simon_turn,
  input  logic [1:0]        simon_num,
  input  logic              simon_pressed,
  input  logic [1:0]        player_num,
  input  logic              player_pressed,
  output logic              player_turn,
  output logic              round_ok,
  output logic              fail,
  output logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W:0]   progress
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RECORD       = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_OK           = 3'd4,
    ST_FAIL         = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(MAX_LEN);

  if (MAX_LEN != (2 ** ADDR_W) || TIMEOUT < 1) begin : g_bad_param
    $error("simon_checker: MAX_LEN must equal 2**ADDR_W and TIMEOUT must be >= 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W:0]   seq_len_q, seq_len_d;
  logic [ADDR_W:0]   progress_q, progress_d;
  logic              simon_pressed_q, player_pressed_q, simon_turn_q;
  logic [1:0]        mem_q [MAX_LEN];
  logic              mem_we;
  logic              simon_rise, player_rise, turn_rise;
  logic              timeout_hit;

  assign simon_rise  = simon_pressed  & ~simon_pressed_q;
  assign player_rise = player_pressed & ~player_pressed_q;
  assign turn_rise   = simon_turn     & ~simon_turn_q;

`ifdef SIMON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Counter only runs in WAIT_PRESS; any other state primes it to zero for the next entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT_PRESS && state_d == ST_WAIT_PRESS) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    progress_d = progress_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (turn_rise) begin
          seq_len_d = '0;
          state_d   = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (!simon_turn) begin
          if (seq_len_q == '0) begin
            state_d = ST_FAIL;
          end else begin
            progress_d = '0;
            state_d    = ST_WAIT_PRESS;
          end
        end else if (simon_rise && seq_len_q != FULL_LEN) begin
          mem_we    = 1'b1;
          seq_len_d = seq_len_q + 1'b1;
        end
      end
      ST_WAIT_PRESS: begin
        // A new Simon turn aborts the check and outranks any player edge.
        if (turn_rise) begin
          seq_len_d = '0;
          state_d   = ST_RECORD;
        end else if (player_rise) begin
          if (player_num == mem_q[progress_q[ADDR_W-1:0]]) state_d = ST_WAIT_RELEASE;
          else                                              state_d = ST_FAIL;
        end else if (timeout_hit) begin
          state_d = ST_FAIL;
        end
      end
      ST_WAIT_RELEASE: begin
        if (turn_rise) begin
          seq_len_d = '0;
          state_d   = ST_RECORD;
        end else if (!player_pressed) begin
          progress_d = progress_q + 1'b1;
          if (progress_q + 1'b1 == seq_len_q) state_d = ST_OK;
          else                                state_d = ST_WAIT_PRESS;
        end
      end
      ST_OK: begin
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        seq_len_d  = '0;
        progress_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      seq_len_q        <= '0;
      progress_q       <= '0;
      simon_pressed_q  <= 1'b0;
      player_pressed_q <= 1'b0;
      simon_turn_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      seq_len_q        <= seq_len_d;
      progress_q       <= progress_d;
      simon_pressed_q  <= simon_pressed;
      player_pressed_q <= player_pressed;
      simon_turn_q     <= simon_turn;
    end
  end

  // Sequence store has no reset; contents are only read below seq_len.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[seq_len_q[ADDR_W-1:0]] <= simon_num;
  end

  assign player_turn = (state_q == ST_WAIT_PRESS) || (state_q == ST_WAIT_RELEASE);
  assign round_ok    = (state_q == ST_OK);
  assign fail        = (state_q == ST_FAIL);
  assign seq_len     = seq_len_q;
  assign progress    = progress_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_checker.sv
// Directed self-checking bench for simon_checker.
`default_nettype none

module tb_simon_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       simon_turn, simon_pressed, player_pressed;
  logic [1:0] simon_num, player_num;
  logic       player_turn, round_ok, fail;
  logic [5:0] seq_len, progress;

  int errors = 0;
  int checks = 0;

  simon_checker #(.MAX_LEN(32), .ADDR_W(5), .TIMEOUT(20)) dut (
    .clk            (clk),
    .reset          (reset),
    .simon_turn     (simon_turn),
    .simon_num      (simon_num),
    .simon_pressed  (simon_pressed),
    .player_num     (player_num),
    .player_pressed (player_pressed),
    .player_turn    (player_turn),
    .round_ok       (round_ok),
    .fail           (fail),
    .seq_len        (seq_len),
    .progress       (progress)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    simon_turn = 1'b1;
    tick();
  endtask

  task automatic end_round();
    simon_turn = 1'b0;
    tick();
  endtask

  task automatic play_note(input logic [1:0] c);
    simon_num     = c;
    simon_pressed = 1'b1;
    tick();
    simon_pressed = 1'b0;
    tick();
  endtask

  task automatic press(input logic [1:0] c);
    player_num     = c;
    player_pressed = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    player_pressed = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    simon_turn = 0; simon_pressed = 0; simon_num = 0;
    player_pressed = 0; player_num = 0;
    tick(); tick();
    if ({player_turn, round_ok, fail} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: actual=%b required=000", {player_turn, round_ok, fail});
    end
    checks++;
    if (seq_len !== 6'd0 || progress !== 6'd0) begin
      errors++; $display("FAIL reset_counts: actual seq_len=%0d progress=%0d required 0/0", seq_len, progress);
    end
    checks++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_match();
    logic [1:0] notes [3] = '{2'd2, 2'd0, 2'd3};
    start_round();
    foreach (notes[i]) play_note(notes[i]);
    if (player_turn !== 1'b0) begin
      errors++; $display("FAIL match_record_turn: actual=%b required=0", player_turn);
    end
    checks++;
    end_round();
    if (player_turn !== 1'b1 || seq_len !== 6'd3) begin
      errors++; $display("FAIL match_enter: actual turn=%b len=%0d required 1/3", player_turn, seq_len);
    end
    checks++;
    foreach (notes[i]) begin
      press(notes[i]);
      if (fail !== 1'b0) begin
        errors++; $display("FAIL match_press%0d: actual fail=%b required 0", i, fail);
      end
      checks++;
      release_btn();
      if (progress !== 6'(i + 1)) begin
        errors++; $display("FAIL match_progress%0d: actual=%0d required=%0d", i, progress, i + 1);
      end
      checks++;
    end
    if (round_ok !== 1'b1 || fail !== 1'b0) begin
      errors++; $display("FAIL match_ok_pulse: actual ok=%b fail=%b required 1/0", round_ok, fail);
    end
    checks++;
    tick();
    if (round_ok !== 1'b0 || seq_len !== 6'd3 || progress !== 6'd3 || player_turn !== 1'b0) begin
      errors++; $display("FAIL match_after: actual ok=%b len=%0d prog=%0d turn=%b required 0/3/3/0",
                         round_ok, seq_len, progress, player_turn);
    end
    checks++;
  endtask

  task automatic test_mismatch();
    start_round();
    play_note(2'd1);
    play_note(2'd1);
    end_round();
    press(2'd1);
    release_btn();
    press(2'd2);
    if (fail !== 1'b1 || round_ok !== 1'b0) begin
      errors++; $display("FAIL mismatch_pulse: actual fail=%b ok=%b required 1/0", fail, round_ok);
    end
    checks++;
    release_btn();
    if (fail !== 1'b0 || seq_len !== 6'd0 || progress !== 6'd0) begin
      errors++; $display("FAIL mismatch_after: actual fail=%b len=%0d prog=%0d required 0/0/0",
                         fail, seq_len, progress);
    end
    checks++;
  endtask

  task automatic test_empty();
    start_round();
    end_round();
    if (fail !== 1'b1 || player_turn !== 1'b0) begin
      errors++; $display("FAIL empty_pulse: actual fail=%b turn=%b required 1/0", fail, player_turn);
    end
    checks++;
    tick();
    if (fail !== 1'b0 || player_turn !== 1'b0) begin
      errors++; $display("FAIL empty_after: actual fail=%b turn=%b required 0/0", fail, player_turn);
    end
    checks++;
  endtask

  task automatic test_full();
    int bad = 0;
    start_round();
    for (int i = 0; i < 32; i++) play_note(2'((i + 1) % 4));
    play_note(2'd2);
    if (seq_len !== 6'd32) begin
      errors++; $display("FAIL full_len: actual=%0d required=32", seq_len);
    end
    checks++;
    end_round();
    for (int i = 0; i < 32; i++) begin
      press(2'((i + 1) % 4));
      if (fail !== 1'b0) bad++;
      release_btn();
    end
    if (round_ok !== 1'b1 || bad != 0 || progress !== 6'd32) begin
      errors++; $display("FAIL full_ok: actual ok=%b fails=%0d prog=%0d required 1/0/32", round_ok, bad, progress);
    end
    checks++;
    tick();
  endtask

  task automatic test_held_and_abort();
    start_round();
    play_note(2'd3);
    play_note(2'd1);
    press(2'd0);
    end_round();
    tick(); tick();
    if (fail !== 1'b0 || progress !== 6'd0 || player_turn !== 1'b1) begin
      errors++; $display("FAIL held_nocompare: actual fail=%b prog=%0d turn=%b required 0/0/1",
                         fail, progress, player_turn);
    end
    checks++;
    release_btn();
    press(2'd3);
    release_btn();
    if (progress !== 6'd1 || round_ok !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL held_fresh: actual prog=%0d ok=%b fail=%b required 1/0/0", progress, round_ok, fail);
    end
    checks++;
    simon_turn = 1'b1;
    tick();
    if (player_turn !== 1'b0 || seq_len !== 6'd0 || fail !== 1'b0 || round_ok !== 1'b0) begin
      errors++; $display("FAIL abort: actual turn=%b len=%0d fail=%b ok=%b required 0/0/0/0",
                         player_turn, seq_len, fail, round_ok);
    end
    checks++;
    play_note(2'd2);
    end_round();
    if (player_turn !== 1'b1 || seq_len !== 6'd1 || progress !== 6'd0) begin
      errors++; $display("FAIL abort_record: actual turn=%b len=%0d prog=%0d required 1/1/0",
                         player_turn, seq_len, progress);
    end
    checks++;
    press(2'd2);
    release_btn();
    if (round_ok !== 1'b1) begin
      errors++; $display("FAIL abort_round_ok: actual=%b required=1", round_ok);
    end
    checks++;
    tick();
  endtask

`ifdef SIMON_TIMEOUT_EN
  task automatic test_timeout();
    start_round();
    play_note(2'd1);
    end_round();
    repeat (19) tick();
    if (fail !== 1'b0) begin
      errors++; $display("FAIL timeout_early: actual=%b required=0", fail);
    end
    checks++;
    tick();
    if (fail !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: actual=%b required=1", fail);
    end
    checks++;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int seen = 0;
    start_round();
    play_note(2'd1);
    play_note(2'd2);
    end_round();
    repeat (1000) begin
      tick();
      if (fail !== 1'b0) seen++;
    end
    if (seen != 0 || player_turn !== 1'b1) begin
      errors++; $display("FAIL no_timeout: actual fails=%0d turn=%b required 0/1", seen, player_turn);
    end
    checks++;
  endtask
`endif

  task automatic test_async_reset();
`ifdef SIMON_TIMEOUT_EN
    start_round();
    play_note(2'd1);
    play_note(2'd2);
    end_round();
`endif
    press(2'd1);
    release_btn();
    press(2'd2);
    if (progress !== 6'd1 || seq_len !== 6'd2 || player_turn !== 1'b1) begin
      errors++; $display("FAIL areset_pre: actual prog=%0d len=%0d turn=%b required 1/2/1",
                         progress, seq_len, player_turn);
    end
    checks++;
    #2 reset = 1'b0;
    #1;
    if ({player_turn, round_ok, fail} !== 3'b000 || seq_len !== 6'd0 || progress !== 6'd0) begin
      errors++; $display("FAIL areset_now: actual flags=%b len=%0d prog=%0d required 000/0/0",
                         {player_turn, round_ok, fail}, seq_len, progress);
    end
    checks++;
    player_pressed = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_empty();
    test_full();
    test_held_and_abort();
`ifdef SIMON_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
